sd_cic_decimator: RTL and testbench

- Receive-side partner of the 3-channel coupled sigma-delta modulator.
- Each clock it takes the 3-bit bitstream, maps every bit to ±1 and sums the three bits.
- The sum runs through a 3rd-order CIC decimation filter, which turns it into signed multi-bit samples at clk/2^LOG2_DECIM.
- Samples are delivered on a valid/ready output port with overrun detection. The block sits between the modulator's sd_out bus and downstream DSP/capture logic.

---
 rtl/sd_pkg.sv | 19 +
 rtl/sd_cic_integrator.sv | 19 +
 rtl/sd_cic_decimator.sv | 89 ++++++++
 tb/tb_sd_cic_decimator.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared constants and helpers for the sigma-delta CIC receive path.
package sd_pkg;

   localparam int CIC_ORDER = 3;
   localparam int SD_LANES  = 3;

   // Worst-case |x| = 3 needs 3 bits; each CIC stage grows by log2(R).
   function automatic int cic_width(input int log2_decim);
      return 3 + CIC_ORDER * log2_decim;
   endfunction

   function automatic logic signed [3:0] lane_to_x(input logic [SD_LANES-1:0] lanes);
      logic [3:0] ones;
      ones = '0;
      for (int i = 0; i < SD_LANES; i++) ones = ones + 4'(lanes[i]);
      return signed'(4'(2 * ones) - 4'(SD_LANES));
   endfunction

endpackage

// File: rtl/sd_cic_integrator.sv
// One modular CIC integrator stage; acc_nxt exposes the value being registered.
module sd_cic_integrator #(
   parameter int W = 21
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] acc,
   output logic [W-1:0] acc_nxt
);

   assign acc_nxt = acc + din;

   always_ff @(posedge clk) begin
      if (rst) acc <= '0;
      else     acc <= acc_nxt;
   end

endmodule

// File: rtl/sd_cic_decimator.sv
// 3-lane sigma-delta bitstream -> 3rd-order CIC decimator with valid/ready output.
module sd_cic_decimator
   import sd_pkg::*;
#(
   parameter int LOG2_DECIM = 6,
   parameter int BITWIDTH   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SD_LANES-1:0] sd_in,
   output logic [BITWIDTH-1:0] dout,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overrun
);

   localparam int CIC_W = cic_width(LOG2_DECIM);

   if (LOG2_DECIM < 1 || LOG2_DECIM > 9) begin : g_bad_decim
      $error("sd_cic_decimator: LOG2_DECIM must be in 1..9");
   end
   if (BITWIDTH < CIC_W) begin : g_bad_width
      $error("sd_cic_decimator: BITWIDTH must be at least 3 + 3*LOG2_DECIM");
   end

   logic signed [3:0]                  x4;
   logic [CIC_ORDER-1:0][CIC_W-1:0]    integ_in, integ, integ_nxt;

   assign x4 = lane_to_x(sd_in);

   // Each stage adds the previous stage's registered value (one cycle skew per stage).
   for (genvar g = 0; g < CIC_ORDER; g++) begin : g_integ
      if (g == 0) begin : g_head
         assign integ_in[g] = {{(CIC_W-4){x4[3]}}, x4};
      end else begin : g_chain
         assign integ_in[g] = integ[g-1];
      end
      sd_cic_integrator #(.W(CIC_W)) u_integ (
         .clk     (clk),
         .rst     (rst),
         .din     (integ_in[g]),
         .acc     (integ[g]),
         .acc_nxt (integ_nxt[g])
      );
   end

   logic [LOG2_DECIM-1:0] phase;
   logic [1:0]            warm;
   logic                  strobe;
   logic [CIC_W-1:0]      s, c1, c2, c3, d1, d2, d3;
   logic signed [CIC_W-1:0] c3_s;

   assign strobe = &phase;
   assign s      = integ_nxt[CIC_ORDER-1];
   assign c1     = s  - d1;
   assign c2     = c1 - d2;
   assign c3     = c2 - d3;
   assign c3_s   = signed'(c3);

   always_ff @(posedge clk) begin
      if (rst) begin
         phase     <= '0;
         warm      <= '0;
         d1        <= '0;
         d2        <= '0;
         d3        <= '0;
         dout      <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         phase <= phase + LOG2_DECIM'(1);
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (strobe) begin
            d1 <= s;
            d2 <= c1;
            d3 <= c2;
            // The first three comb outputs are still filling the delay line.
            if (warm != 2'd3) begin
               warm <= warm + 2'd1;
            end else begin
               dout      <= BITWIDTH'(c3_s);
               out_valid <= 1'b1;
               if (out_valid && !out_ready) overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Scoreboard bench: an FIR (box^3) reference model predicts every decimated sample.
module tb_sd_cic_decimator;

   localparam int R     = 64;
   localparam int CIC_W = 21;
   localparam int NT    = 3 * R - 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  sd_in = 3'b000;
   logic [31:0] dout;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        overrun;

   sd_cic_decimator #(.LOG2_DECIM(6), .BITWIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .sd_in     (sd_in),
      .dout      (dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   int          h [NT];
   int          h2 [2*R-1];
   int          xs [$];
   logic [31:0] sb [$];
   int          n;
   logic [31:0] exp_dout;
   logic        exp_valid, exp_ovr;
   bit          dc_on;
   logic [31:0] dc_exp;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at sample %0d",
                    tag, $signed(act), act, $signed(exp), exp, n);
   endtask

   // Direct convolution; integrator pipeline delays the input by two samples.
   function automatic logic [31:0] model_out(input int nn);
      longint          y;
      logic [63:0]     yv;
      logic [CIC_W-1:0] t;
      y = 0;
      for (int j = 0; j < NT; j++) begin
         int k;
         k = nn - 2 - j;
         if (k >= 1) y += longint'(h[j]) * longint'(xs[k-1]);
      end
      yv = 64'(y);
      t  = yv[CIC_W-1:0];
      return 32'(signed'(t));
   endfunction

   task automatic step(input logic [2:0] sd, input logic rdy);
      int   nn;
      logic strobe_out;
      sd_in     = sd;
      out_ready = rdy;
      xs.push_back(2 * $countones(sd) - 3);
      nn = n + 1;
      strobe_out = (nn % R == 0) && (nn >= 4 * R);
      if (strobe_out) sb.push_back(model_out(nn));
      if (exp_valid && rdy) chk("xfer", dout, exp_dout);
      if (strobe_out) begin
         if (exp_valid && !rdy) exp_ovr = 1'b1;
         exp_valid = 1'b1;
      end else if (exp_valid && rdy) begin
         exp_valid = 1'b0;
      end
      @(posedge clk); #1;
      n = nn;
      if (strobe_out) begin
         exp_dout = sb.pop_front();
         if (dc_on) chk("dc", dout, dc_exp);
      end
      chk("valid", {31'd0, out_valid}, {31'd0, exp_valid});
      chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
      if (exp_valid) chk("dout", dout, exp_dout);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      sd_in     = 3'($urandom_range(0, 7));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0;
      xs.delete();
      sb.delete();
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_dout  = '0;
      chk("rst_dout", dout, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
   endtask

   task automatic run_const(input logic [2:0] sd, input logic [31:0] k, input int cycles);
      do_reset();
      dc_on  = 1'b1;
      dc_exp = k;
      for (int i = 0; i < cycles; i++) step(sd, 1'b1);
      dc_on = 1'b0;
   endtask

   initial begin
      for (int a = 0; a < R; a++)
         for (int b = 0; b < R; b++) h2[a+b] += 1;
      for (int a = 0; a < 2*R-1; a++)
         for (int b = 0; b < R; b++) h[a+b] += h2[a];
      n = 0; dc_on = 1'b0; dc_exp = '0;
      exp_valid = 1'b0; exp_ovr = 1'b0; exp_dout = '0;

      @(posedge clk); #1;
      do_reset();
      do_reset();

      run_const(3'b111, 32'd786432, 7 * R + 3);
      run_const(3'b000, -32'sd786432, 5 * R + 3);
      run_const(3'b110, 32'd262144, 5 * R + 3);
      run_const(3'b100, -32'sd262144, 5 * R + 3);

      // Alternating input: long enough for the integrators to wrap many times.
      do_reset();
      dc_on = 1'b1; dc_exp = 32'd0;
      for (int i = 0; i < 20000; i++) step((i % 2 == 0) ? 3'b111 : 3'b000, 1'b1);
      dc_on = 1'b0;

      // Ready rises exactly on a strobe, then two strobes go unaccepted.
      do_reset();
      for (int i = 0; i < 5 * R - 1; i++) step(3'b111, 1'b0);
      step(3'b111, 1'b1);
      chk("strobe_xfer_no_ovr", {31'd0, overrun}, 32'd0);
      chk("strobe_xfer_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 2 * R; i++) step(3'b111, 1'b0);
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      chk("ovr_valid", {31'd0, out_valid}, 32'd1);
      step(3'b111, 1'b1);
      chk("ovr_drop", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 10; i++) step(3'b111, 1'b1);

      // Random bitstream and random back-pressure.
      do_reset();
      for (int i = 0; i < 3000; i++)
         step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

      // Reset mid-frame, then the warm-up restarts from scratch.
      do_reset();
      for (int i = 0; i < 1000; i++) step(3'b111, 1'b1);
      do_reset();
      dc_on = 1'b1; dc_exp = 32'd786432;
      for (int i = 0; i < 4 * R + 10; i++) step(3'b111, 1'b1);
      dc_on = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
